// File: rtl/pll_lock_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_lock_reset_ctrl
//
// Purpose:
//   Produces a clean fabric reset from a PLL lock indication. The
//   asynchronous lock input is synchronized first. It must then stay high
//   (with INIT_DONE high) for LOCK_FILTER consecutive cycles. Reset is then
//   held for RELEASE_DELAY more cycles before it is released. A drop of lock
//   after qualification counts as a loss and puts the block back into
//   reset. Software can request a short fabric reset while running.
//
// Parameters:
//   LOCK_FILTER    consecutive synchronized-lock cycles needed (1..65535)
//   RELEASE_DELAY  cycles reset is held after qualification  (1..65535)
//
// Ports:
//   clk_i             PLL reference clock; all logic on its rising edge
//   resetn_i          synchronous active-low block reset
//   pll_lock_i        asynchronous PLL lock indication
//   init_done_i       device initialization complete (level, clk_i domain)
//   sw_rst_req_i      single-cycle software fabric-reset request
//   fabric_reset_n_o  registered active-low fabric reset
//   lock_stable_o     registered; high while lock is qualified
//   state_o           current FSM state encoding
//   loss_count_o      saturating count of qualified-lock losses
// ---------------------------------------------------------------------------
module pll_lock_reset_ctrl #(
  parameter int unsigned LOCK_FILTER   = 256,
  parameter int unsigned RELEASE_DELAY = 16
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       pll_lock_i,
  input  logic       init_done_i,
  input  logic       sw_rst_req_i,
  output logic       fabric_reset_n_o,
  output logic       lock_stable_o,
  output logic [1:0] state_o,
  output logic [7:0] loss_count_o
);

  typedef enum logic [1:0] {
    WAIT_LOCK   = 2'b00,
    FILTER      = 2'b01,
    RELEASE_DLY = 2'b10,
    RUN         = 2'b11
  } state_e;

  // Terminal counts. Each phase ends when its terminal count is reached, so
  // the 16-bit counter never wraps.
  localparam logic [15:0] FilterLast  = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] ReleaseLast = 16'(RELEASE_DELAY - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  loss_q, loss_d;
  logic        sync1_q, sync2_q;
  logic        frn_q, stable_q;
  logic        loss_event;

  // State, counter, synchronizer and output registers. Reset is synchronous
  // and takes priority over every other input. This includes the
  // synchronizer flops, so a lock that stayed high across a reset must be
  // requalified from the beginning.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= 16'd0;
      loss_q   <= 8'd0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      frn_q    <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loss_q   <= loss_d;
      sync1_q  <= pll_lock_i;
      sync2_q  <= sync1_q;
      frn_q    <= (state_d == RUN);
      stable_q <= (state_d == RELEASE_DLY) || (state_d == RUN);
    end
  end

  // Next-state logic. The priority is: lock loss, then INIT_DONE low, then
  // the software request, then counter progress. A lock drop is counted as a
  // loss only after lock has been qualified (RELEASE_DLY or RUN). A drop
  // during FILTER only restarts qualification.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = 16'd0;
        if (sync2_q && init_done_i) begin
          state_d = FILTER;
        end
      end
      FILTER: begin
        if (!sync2_q || !init_done_i) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else if (cnt_q == FilterLast) begin
          state_d = RELEASE_DLY;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE_DLY: begin
        // The software request is ignored here, so an in-progress delay is
        // never restarted.
        if (!sync2_q) begin
          state_d    = WAIT_LOCK;
          cnt_d      = 16'd0;
          loss_event = 1'b1;
        end else if (!init_done_i) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else if (cnt_q == ReleaseLast) begin
          state_d = RUN;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (!sync2_q) begin
          state_d    = WAIT_LOCK;
          cnt_d      = 16'd0;
          loss_event = 1'b1;
        end else if (!init_done_i) begin
          state_d = WAIT_LOCK;
          cnt_d   = 16'd0;
        end else if (sw_rst_req_i) begin
          state_d = RELEASE_DLY;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // The loss counter saturates at 255 instead of wrapping, so a flapping PLL
  // cannot make it look healthy again.
  always_comb begin
    loss_d = loss_q;
    if (loss_event && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  assign fabric_reset_n_o = frn_q;
  assign lock_stable_o    = stable_q;
  assign state_o          = state_q;
  assign loss_count_o     = loss_q;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_reset_ctrl
//
// Purpose:
//   Self-checking bench for pll_lock_reset_ctrl with LOCK_FILTER=4 and
//   RELEASE_DELAY=3. Directed scenarios are followed by a randomized phase.
//   Every cycle is compared against an "age" model. The age is the number of
//   edges since qualification began; state and outputs follow from it.
// ---------------------------------------------------------------------------
module tb_pll_lock_reset_ctrl;

  localparam int LF = 4;
  localparam int RD = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       pllLock = 1'b0;
  logic       initDone = 1'b0;
  logic       swRstReq = 1'b0;
  logic       fabricResetN;
  logic       lockStable;
  logic [1:0] stateO;
  logic [7:0] lossCount;

  int vectors = 0;
  int miscompares = 0;
  int edgeNum = 0;

  // Reference model state.
  // mAge = -1 : waiting for lock
  // 0..LF-1   : filtering
  // LF..LF+RD-1 : release delay
  // LF+RD     : running
  int   mAge = -1;
  int   mLoss = 0;
  logic mSync1 = 1'b0;
  logic mSync2 = 1'b0;

  int firstFilter, firstStable, firstRun, lossEdge, lossStart;
  int lowCount, stableLow, relockEdge, riseEdge;

  pll_lock_reset_ctrl #(
    .LOCK_FILTER  (LF),
    .RELEASE_DELAY(RD)
  ) dut (
    .clk_i           (clk),
    .resetn_i        (resetN),
    .pll_lock_i      (pllLock),
    .init_done_i     (initDone),
    .sw_rst_req_i    (swRstReq),
    .fabric_reset_n_o(fabricResetN),
    .lock_stable_o   (lockStable),
    .state_o         (stateO),
    .loss_count_o    (lossCount)
  );

  // Free-running reference clock, 10 time units per period.
  always #5 clk = ~clk;

  // Advances the model by one rising edge, using the inputs that are
  // currently being driven.
  task automatic modelEdge();
    if (!resetN) begin
      mAge   = -1;
      mLoss  = 0;
      mSync1 = 1'b0;
      mSync2 = 1'b0;
    end else begin
      if (!(mSync2 && initDone)) begin
        if (!mSync2 && mAge >= LF && mLoss < 255) mLoss++;
        mAge = -1;
      end else if (mAge < 0) begin
        mAge = 0;
      end else if (swRstReq && mAge >= LF + RD) begin
        mAge = LF;
      end else if (mAge < LF + RD) begin
        mAge++;
      end
      mSync2 = mSync1;
      mSync1 = pllLock;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int expState;
    expState = (mAge < 0) ? 0 : (mAge < LF) ? 1 : (mAge < LF + RD) ? 2 : 3;
    check("state", 32'(stateO), 32'(expState));
    check("fabric_reset_n", 32'(fabricResetN), (mAge >= LF + RD) ? 32'd1 : 32'd0);
    check("lock_stable", 32'(lockStable), (mAge >= LF) ? 32'd1 : 32'd0);
    check("loss_count", 32'(lossCount), 32'(mLoss));
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic i,
                               input logic s);
    resetN   = r;
    pllLock  = l;
    initDone = i;
    swRstReq = s;
    modelEdge();
    @(posedge clk);
    edgeNum++;
    #1;
    checkOutput();
  endtask

  // Directed scenarios first, then randomized stimulus. Every step is also
  // checked against the model.
  initial begin
    // Power-up: reset is held for edges 1..5. Lock is first sampled high at
    // edge 10.
    firstFilter = -1; firstStable = -1; firstRun = -1;
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 6; i <= 9; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 10; i <= 24; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      if (stateO == 2'd1 && firstFilter < 0) firstFilter = edgeNum;
      if (lockStable && firstStable < 0) firstStable = edgeNum;
      if (fabricResetN && firstRun < 0) firstRun = edgeNum;
    end
    check("powerup_filter_edge", 32'(firstFilter), 32'd12);
    check("powerup_stable_edge", 32'(firstStable), 32'd16);
    check("powerup_run_edge", 32'(firstRun), 32'd19);

    // Loss in RUN: the fabric reset drops two edges after the low sample.
    lossStart = edgeNum + 1;
    lossEdge = -1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      if (!fabricResetN && !lockStable && lossEdge < 0) lossEdge = edgeNum;
    end
    check("loss_latency", 32'(lossEdge - lossStart), 32'd2);
    check("loss_count_one", 32'(lossCount), 32'd1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);

    // Soft reset in RUN: the fabric reset is low for exactly RELEASE_DELAY
    // cycles while lock_stable stays high.
    lowCount = 0; stableLow = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    if (!fabricResetN) lowCount++;
    if (!lockStable) stableLow++;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      if (!fabricResetN) lowCount++;
      if (!lockStable) stableLow++;
    end
    check("soft_reset_low_cycles", 32'(lowCount), 32'd3);
    check("soft_reset_stable_drops", 32'(stableLow), 32'd0);

    // A software request coinciding with a lock loss: the loss wins.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    check("sw_vs_loss_state", 32'(stateO), 32'd0);
    check("sw_vs_loss_count", 32'(lossCount), 32'd2);

    // Filter abort: lock is high for 3 cycles, low for 1, then high again.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    relockEdge = edgeNum + 1;
    riseEdge = -1;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      if (fabricResetN && riseEdge < 0) riseEdge = edgeNum;
    end
    check("filter_abort_relock_latency", 32'(riseEdge - relockEdge), 32'd9);
    check("filter_abort_loss_count", 32'(lossCount), 32'd2);

    // INIT_DONE drops in RUN: back to WAIT_LOCK on the next edge, not
    // counted as a loss.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check("init_drop_state", 32'(stateO), 32'd0);
    check("init_drop_frn", 32'(fabricResetN), 32'd0);
    check("init_drop_loss", 32'(lossCount), 32'd2);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);

    // A lock glitch between edges is never sampled and has no effect.
    pllLock = 1'b0;
    #2;
    pllLock = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check("glitch_state", 32'(stateO), 32'd3);

    // Reset pulse in RELEASE_DLY. Lock stays high across the reset, so
    // qualification must restart from scratch.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check("requal_release_state", 32'(stateO), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    check("rst_state", 32'(stateO), 32'd0);
    check("rst_frn", 32'(fabricResetN), 32'd0);
    check("rst_stable", 32'(lockStable), 32'd0);
    check("rst_loss", 32'(lossCount), 32'd0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);

    // Saturation: 260 loss / re-lock cycles.
    for (int n = 0; n < 260; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    end
    check("loss_saturation", 32'(lossCount), 32'd255);

    // Randomized traffic: lock drops are rare, INIT_DONE drops are rarer,
    // and there are occasional resets and software requests.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 23) != 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
